// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic datapath
// (skew feeder, conv_ctrl, array).
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      STREAM = 2'b01,
      DRAIN  = 2'b10
   } feeder_state_t;

   localparam int DEFAULT_ROW = 32;
   localparam int DEFAULT_DW  = 8;

endpackage

// File: rtl/skew_delay_line.sv
// Valid+data shift register of DEPTH stages with a synchronous flush.
// With DEPTH=0 the input passes straight through.
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          flush,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic [DW-1:0] o_data
);

   if (DEPTH == 0) begin : g_wire
      // Clock, reset and flush have no role in a zero-depth lane.
      logic w_unusedCtl;
      assign w_unusedCtl = clk ^ nrst ^ flush;
      assign o_valid     = i_valid;
      assign o_data      = i_data;
   end else begin : g_shift
      logic [DEPTH-1:0] r_validPipe;
      logic [DW-1:0]    r_dataPipe [DEPTH];

      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            r_validPipe <= '0;
            for (int i = 0; i < DEPTH; i++) r_dataPipe[i] <= '0;
         end else if (flush) begin
            r_validPipe <= '0;
            for (int i = 0; i < DEPTH; i++) r_dataPipe[i] <= '0;
         end else begin
            r_validPipe[0] <= i_valid;
            r_dataPipe[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
               r_validPipe[i] <= r_validPipe[i-1];
               r_dataPipe[i]  <= r_dataPipe[i-1];
            end
         end
      end

      assign o_valid = r_validPipe[DEPTH-1];
      assign o_data  = r_dataPipe[DEPTH-1];
   end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews ROW-wide activation beats into a diagonal wavefront (row r delayed r
// cycles), applies the per-row enable mask and drains the pipe after each tile.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int ROW   = DEFAULT_ROW,
   parameter int DW    = DEFAULT_DW,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              clear,
   input  logic [ROW*DW-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   input  logic [ROW-1:0]    input_en,
   output logic [ROW*DW-1:0] row_data,
   output logic [ROW-1:0]    row_valid,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  beat_count
);

   localparam int DCW = $clog2(ROW);

   feeder_state_t     r_state, w_nextState;
   logic [DCW-1:0]    r_drainCnt, w_nextDrainCnt;
   logic              r_resetDone;
   logic [CNT_W-1:0]  r_beatCount;
   logic [ROW*DW-1:0] r_inData;
   logic              r_inValid;
   logic              w_accept;
   logic [ROW-1:0]    w_stageValid;
   logic [ROW*DW-1:0] w_stageData;

   // r_resetDone keeps the port closed for the first cycle out of reset.
   assign in_ready   = r_resetDone && !clear && (r_state != DRAIN);
   assign w_accept   = in_valid && in_ready;
   assign busy       = (r_state != IDLE);
   assign beat_count = r_beatCount;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state     <= IDLE;
         r_drainCnt  <= '0;
         r_resetDone <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_drainCnt  <= w_nextDrainCnt;
         r_resetDone <= 1'b1;
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_nextDrainCnt = r_drainCnt;
      done           = 1'b0;
      case (r_state)
         IDLE, STREAM: begin
            if (w_accept) begin
               w_nextState = in_last ? DRAIN : STREAM;
               if (in_last) w_nextDrainCnt = DCW'(ROW - 1);
            end
         end
         DRAIN: begin
            if (r_drainCnt == '0) begin
               w_nextState = IDLE;
               done        = 1'b1;
            end else begin
               w_nextDrainCnt = r_drainCnt - DCW'(1);
            end
         end
         default: w_nextState = IDLE;
      endcase
      // An abort wins over any transition and suppresses the done pulse.
      if (clear) begin
         w_nextState    = IDLE;
         w_nextDrainCnt = '0;
         done           = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_beatCount <= '0;
         r_inValid   <= 1'b0;
         r_inData    <= '0;
      end else if (clear) begin
         r_beatCount <= '0;
         r_inValid   <= 1'b0;
         r_inData    <= '0;
      end else begin
         r_inValid <= w_accept;
         r_inData  <= w_accept ? in_data : '0;
         if (w_accept) begin
            if (r_state == IDLE)
               r_beatCount <= CNT_W'(1);
            else if (r_beatCount != '1)
               r_beatCount <= r_beatCount + CNT_W'(1);
         end
      end
   end

   // Lane r gets r extra stages behind the shared input register.
   for (genvar r = 0; r < ROW; r++) begin : g_lane
      skew_delay_line #(
         .DEPTH (r),
         .DW    (DW)
      ) u_delay (
         .clk     (clk),
         .nrst    (nrst),
         .flush   (clear),
         .i_valid (r_inValid),
         .i_data  (r_inData[r*DW +: DW]),
         .o_valid (w_stageValid[r]),
         .o_data  (w_stageData[r*DW +: DW])
      );

      assign row_valid[r]          = w_stageValid[r] && input_en[r];
      assign row_data[r*DW +: DW]  = row_valid[r] ? w_stageData[r*DW +: DW] : '0;
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed tiles plus random traffic, checked
// every cycle against a beat-history model of the skewed wavefront.
module tb_systolic_skew_feeder;

   localparam int ROW   = 4;
   localparam int DW    = 8;
   localparam int CNT_W = 4;
   localparam int HIST  = 8192;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic              clk      = 1'b0;
   logic              nrst     = 1'b0;
   logic              clear    = 1'b0;
   logic [ROW*DW-1:0] in_data  = '0;
   logic              in_valid = 1'b0;
   logic              in_last  = 1'b0;
   logic [ROW-1:0]    input_en = '1;
   logic              in_ready;
   logic [ROW*DW-1:0] row_data;
   logic [ROW-1:0]    row_valid;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  beat_count;

   int checks    = 0;
   int fails     = 0;
   int maskHits  = 0;
   bit maskWatch = 0;

   // Model: history of accepted beats by edge number, plus tile bookkeeping.
   int                cyc        = 0;
   int                lastFlush  = 0;
   int                drainLast  = -100;
   int                mBeat      = 0;
   bit                tileOpen   = 0;
   bit                mResetDone = 0;
   bit                accValid [HIST];
   logic [ROW*DW-1:0] accData  [HIST];

   systolic_skew_feeder #(
      .ROW   (ROW),
      .DW    (DW),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .clear      (clear),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .input_en   (input_en),
      .row_data   (row_data),
      .row_valid  (row_valid),
      .busy       (busy),
      .done       (done),
      .beat_count (beat_count)
   );

   always #5 clk = ~clk;

   // The tile's last beat leaves lane ROW-1 ROW-1 cycles after its acceptance.
   function automatic bit inDrainM();
      return (drainLast >= 0) && (cyc >= drainLast) && (cyc <= drainLast + ROW - 1);
   endfunction

   function automatic bit expReady();
      return nrst && mResetDone && !clear && !inDrainM();
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic l, input logic [ROW*DW-1:0] d,
                                input logic [ROW-1:0] en, input logic clr);
      @(posedge clk);
      #1;
      in_valid = v;
      in_last  = l;
      in_data  = d;
      input_en = en;
      clear    = clr;
   endtask

   task automatic idleCycles(input int n, input logic [ROW-1:0] en);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, en, 1'b0);
   endtask

   // Advance the model at every edge using the inputs that were stable before it.
   always @(posedge clk) begin
      bit rdy;
      rdy = expReady();
      cyc++;
      if (cyc >= HIST) begin
         $display("[TB] FAIL cycle_budget: got %0d expected below %0d", cyc, HIST);
         $fatal(1, "[TB] cycle budget exhausted");
      end
      accValid[cyc] = 1'b0;
      if (!nrst) begin
         lastFlush  = cyc;
         mResetDone = 1'b0;
      end else begin
         if (clear) begin
            lastFlush = cyc;
            tileOpen  = 1'b0;
            drainLast = -100;
            mBeat     = 0;
         end else if (in_valid && rdy) begin
            accValid[cyc] = 1'b1;
            accData[cyc]  = in_data;
            if (!tileOpen) begin
               tileOpen = 1'b1;
               mBeat    = 1;
            end else if (mBeat < MAXC) begin
               mBeat++;
            end
            if (in_last) begin
               tileOpen  = 1'b0;
               drainLast = cyc;
            end
         end
         mResetDone = 1'b1;
      end
   end

   always @(negedge nrst) begin
      lastFlush  = cyc;
      tileOpen   = 1'b0;
      drainLast  = -100;
      mBeat      = 0;
      mResetDone = 1'b0;
   end

   // Mid-cycle compare: lane r now shows the beat accepted r edges ago, if unflushed and enabled.
   always @(negedge clk) begin
      logic [ROW-1:0]    ev;
      logic [ROW*DW-1:0] ed;
      int                e;
      ev = '0;
      ed = '0;
      for (int r = 0; r < ROW; r++) begin
         e = cyc - r;
         if (e > lastFlush && accValid[e] && input_en[r]) begin
            ev[r]          = 1'b1;
            ed[r*DW +: DW] = accData[e][r*DW +: DW];
         end
      end
      checkOutput("row_valid", 32'(row_valid), 32'(ev));
      checkOutput("row_data", row_data, ed);
      checkOutput("in_ready", 32'(in_ready), 32'(expReady()));
      checkOutput("busy", 32'(busy), 32'(nrst && (tileOpen || inDrainM())));
      checkOutput("done", 32'(done), 32'(nrst && !clear && drainLast >= 0 && cyc == drainLast + ROW - 1));
      checkOutput("beat_count", 32'(beat_count), 32'(mBeat));
      if (maskWatch && (row_valid[1] || row_valid[3])) maskHits++;
   end

   initial begin
      repeat (2) @(posedge clk);
      #2 nrst = 1'b1;

      // Three back-to-back beats, last on beat 2.
      applyStimulus(1'b1, 1'b0, 32'h10101010, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h11111111, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h12121212, 4'hF, 1'b0);
      idleCycles(1, 4'hF);
      @(negedge clk);
      checkOutput("s1_wave_valid", 32'(row_valid), 32'h7);
      checkOutput("s1_wave_data", row_data, 32'h00101112);
      checkOutput("s1_ready_drain", 32'(in_ready), 32'h0);
      idleCycles(3, 4'hF);
      @(negedge clk);
      checkOutput("s1_done", 32'(done), 32'h1);
      checkOutput("s1_lane3", row_data, 32'h12000000);
      checkOutput("s1_count", 32'(beat_count), 32'h3);
      idleCycles(1, 4'hF);
      @(negedge clk);
      checkOutput("s1_ready_back", 32'(in_ready), 32'h1);
      checkOutput("s1_done_gone", 32'(done), 32'h0);

      // Two-cycle bubble between beats.
      applyStimulus(1'b1, 1'b0, 32'h23222120, 4'hF, 1'b0);
      idleCycles(2, 4'hF);
      applyStimulus(1'b1, 1'b1, 32'h33323130, 4'hF, 1'b0);
      idleCycles(1, 4'hF);
      @(negedge clk);
      checkOutput("s2_bubble_valid", 32'(row_valid), 32'h9);
      checkOutput("s2_bubble_data", row_data, 32'h23000030);
      idleCycles(4, 4'hF);

      // Rows 1 and 3 masked off for the whole tile.
      maskWatch = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h43424140, 4'h5, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h53525150, 4'h5, 1'b0);
      idleCycles(3, 4'h5);
      @(negedge clk);
      checkOutput("s3_lane2_valid", 32'(row_valid), 32'h4);
      checkOutput("s3_lane2_data", row_data, 32'h00520000);
      idleCycles(1, 4'h5);
      @(negedge clk);
      checkOutput("s3_done", 32'(done), 32'h1);
      checkOutput("s3_masked_out", 32'(row_valid), 32'h0);
      maskWatch = 1'b0;
      checkOutput("s3_mask_hits", 32'(maskHits), 32'h0);
      idleCycles(1, 4'hF);

      // One-beat tile straight from IDLE.
      applyStimulus(1'b1, 1'b1, 32'h64636261, 4'hF, 1'b0);
      idleCycles(1, 4'hF);
      @(negedge clk);
      checkOutput("s4_busy", 32'(busy), 32'h1);
      checkOutput("s4_ready", 32'(in_ready), 32'h0);
      checkOutput("s4_lane0", row_data, 32'h00000061);
      idleCycles(3, 4'hF);
      @(negedge clk);
      checkOutput("s4_done", 32'(done), 32'h1);
      checkOutput("s4_count", 32'(beat_count), 32'h1);
      checkOutput("s4_lane3", row_data, 32'h64000000);
      idleCycles(1, 4'hF);

      // Abort while lane 2 holds the last beat during drain.
      applyStimulus(1'b1, 1'b0, 32'h73727170, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h83828180, 4'hF, 1'b0);
      idleCycles(2, 4'hF);
      applyStimulus(1'b0, 1'b0, '0, 4'hF, 1'b1);
      @(negedge clk);
      checkOutput("s5_pre_valid", 32'(row_valid), 32'hC);
      checkOutput("s5_pre_data", row_data, 32'h73820000);
      applyStimulus(1'b0, 1'b0, '0, 4'hF, 1'b0);
      @(negedge clk);
      checkOutput("s5_flushed", 32'(row_valid), 32'h0);
      checkOutput("s5_ready", 32'(in_ready), 32'h1);
      checkOutput("s5_idle", 32'(busy), 32'h0);
      checkOutput("s5_no_done", 32'(done), 32'h0);
      idleCycles(4, 4'hF);

      // Long tile saturates the beat counter.
      for (int b = 0; b < 20; b++) applyStimulus(1'b1, b == 19, ROW*DW'($urandom), 4'hF, 1'b0);
      idleCycles(4, 4'hF);
      @(negedge clk);
      checkOutput("s6_done", 32'(done), 32'h1);
      checkOutput("s6_saturated", 32'(beat_count), 32'(MAXC));
      idleCycles(1, 4'hF);

      // Asynchronous reset mid-stream, then a fresh two-beat tile.
      applyStimulus(1'b1, 1'b0, 32'h93929190, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h97969594, 4'hF, 1'b0);
      #1 nrst = 1'b0;
      #1;
      checkOutput("s7_rst_valid", 32'(row_valid), 32'h0);
      checkOutput("s7_rst_data", row_data, 32'h0);
      checkOutput("s7_rst_busy", 32'(busy), 32'h0);
      checkOutput("s7_rst_ready", 32'(in_ready), 32'h0);
      checkOutput("s7_rst_count", 32'(beat_count), 32'h0);
      applyStimulus(1'b0, 1'b0, '0, 4'hF, 1'b0);
      #1 nrst = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'hA3A2A1A0, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'hB3B2B1B0, 4'hF, 1'b0);
      idleCycles(4, 4'hF);
      @(negedge clk);
      checkOutput("s7_done", 32'(done), 32'h1);
      checkOutput("s7_count", 32'(beat_count), 32'h2);
      checkOutput("s7_lane3", row_data, 32'hB3000000);
      idleCycles(1, 4'hF);

      // Random traffic: valid, last, mask and abort all vary.
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 9) < 7,
                       $urandom_range(0, 5) == 0,
                       ROW*DW'($urandom),
                       ($urandom_range(0, 3) == 0) ? ROW'($urandom) : 4'hF,
                       $urandom_range(0, 49) == 0);
      end
      idleCycles(ROW + 2, 4'hF);
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream feeder for the systolic array.
- Accepts one ROW-wide activation vector per beat over a valid/ready handshake.
- Delays row r by r cycles, producing the diagonal wavefront the array expects.
- Applies the per-row input_en mask driven by conv_ctrl and drains the skew pipeline after the last beat, so conv_ctrl and the array see a fully flushed operand stream.

Parameters:
- ROW, 32, number of systolic rows (lanes); must be >= 2.
- DW, 8, bits per activation element.
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; flushes all delay lines and returns to IDLE.
- in_data  input  ROW*DW  activation vector; lane r occupies bits [r*DW +: DW].
- in_valid  input  1  in_data/in_last are valid.
- in_last  input  1  marks the final beat of a tile; sampled only on acceptance.
- in_ready  output  1  feeder can accept a beat this cycle.
- input_en  input  ROW  per-row enable from conv_ctrl; sampled at the output stage.
- row_data  output  ROW*DW  skewed data to the array rows.
- row_valid  output  ROW  per-row qualifier.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse: the tile has fully left the skew pipeline.
- beat_count  output  CNT_W  beats accepted in the current tile.

Behaviour:
- Reset values, applied on nrst low and on clear: state=IDLE, all delay stages zero/invalid, row_data=0, row_valid=0, done=0, beat_count=0, in_ready=0 for the reset cycle only.
- Acceptance: a beat is accepted at a rising edge where in_valid && in_ready.
- in_ready is 1 in IDLE and STREAM, 0 in DRAIN, and 0 while clear=1.
- States:
  - IDLE: acceptance moves to STREAM; with in_last also set, goes directly to DRAIN. beat_count is reset to 0 on the first acceptance, then incremented.
  - STREAM: each acceptance increments beat_count, saturating at all-ones. A cycle with no acceptance inserts a bubble (lane valid=0, data=0). An accepted in_last moves to DRAIN.
  - DRAIN: a drain counter loads ROW-1 on entry and decrements each cycle while bubbles are inserted. At 0 → IDLE. in_valid is ignored.
- Skew timing: lane r passes through r register stages after the lane-0 input register. If a beat is accepted at edge E, lane r appears on row_data during the cycle after edge E+r. Lane 0 therefore has 1-cycle latency and lane ROW-1 has ROW-cycle latency.
- Masking: row_valid[r] = stage_valid[r] && input_en[r]. row_data lane r is 0 whenever row_valid[r]=0. Masked data is discarded; the delay line keeps advancing and there is no back-pressure from the array.
- done: high in exactly the cycle in which lane ROW-1 of the last beat is presented, i.e. the last cycle of DRAIN. beat_count holds its value until the next tile's first acceptance.
- Simultaneous events:
  - clear has priority over acceptance and over the state transition.
  - An in_last beat accepted in IDLE is a one-beat tile.
  - A new tile cannot be accepted until state returns to IDLE; there is no overlap of tiles in the skew pipeline.
- Reset or clear mid-stream or mid-drain: no done pulse is generated, and in-flight data is lost.
- Arithmetic: drain counter width is $clog2(ROW). beat_count saturates and never wraps.

Decomposition:
- systolic_pkg holds:
  - feeder_state_t enum: IDLE=2'b00, STREAM=2'b01, DRAIN=2'b10.
  - Default DW and ROW constants shared with conv_ctrl.
- Sub-module skew_delay_line (parameters DEPTH, DW): valid+data shift register with a synchronous flush input. It is instantiated once per lane r in a generate loop with DEPTH=r; DEPTH=0 degenerates to a wire.

Test Plan:
All scenarios use ROW=4, DW=8.
- Single tile: 3 back-to-back beats with lane values 0x10+beat, last on beat 2 → lane r shows beat b at cycle (accept_b+1+r). done asserts in the cycle lane 3 shows beat 2, 4 cycles after its acceptance. beat_count=3. in_ready low for 4 cycles, then 1.
- Bubble insertion: in_valid low for 2 cycles between beat 0 and beat 1 → every lane shows 2 invalid zero cycles between its two values; skew is preserved.
- Masking: input_en=4'b0101 during the stream → row_valid[1] and row_valid[3] never assert and their row_data lanes stay 0. Lanes 0 and 2 are unaffected, and done timing is unchanged.
- One-beat tile: in_valid=in_last=1 in IDLE → state goes straight to DRAIN, done after 4 cycles, beat_count=1.
- Abort: clear pulsed while lane 2 holds valid data in DRAIN → the next cycle has all row_valid=0, state IDLE, in_ready=1, and no done pulse.
- Async reset: nrst dropped mid-STREAM, mid-cycle → outputs zero immediately. After release, a fresh 2-beat tile behaves as in scenario 1.
